// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner.
//   - rpt_state_e   : per-channel auto-repeat FSM encoding
//   - DEF_*         : default timing for the 100 MHz board clock
//   - cnt_width()   : width of the shared debounce/repeat counter
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_N_BTN           = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;  // 100 ms

  // Counters only ever reach (largest period - 1), so $clog2 of the
  // largest period is enough; clamp to 1 bit for the all-ones corner.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter and
// auto-repeat FSM.
//   clk_i, rst_i : clock, synchronous active-high reset
//   raw_i        : asynchronous raw button, active-high
//   level_o      : debounced level
//   press_o      : one-cycle strobe on accepted rising level
//   release_o    : one-cycle strobe on accepted falling level
//   event_o      : press or auto-repeat strobe
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic event_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          event_q, event_d;
  logic          rpt_d;
  rpt_state_e    state_q, state_d;
  logic [CW-1:0] rcnt_q, rcnt_d;

  always_comb begin
    level_d   = level_q;
    dcnt_d    = dcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rpt_d     = 1'b0;

    // Debounce: any matching cycle restarts the count.
    if (sync2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d   = sync2_q;
      dcnt_d    = '0;
      press_d   = sync2_q;
      release_d = ~sync2_q;
    end else begin
      dcnt_d = dcnt_q + CW'(1);
    end

    // The FSM reacts to the strobe being registered this edge, so the
    // hold period is counted from the press cycle itself. A release
    // overrides everything, which also drops a repeat due this edge.
    if (release_d) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d = HOLD;
            rcnt_d  = '0;
          end
        end
        HOLD: begin
          if (rcnt_q == CW'(HOLD_CYCLES - 1)) begin
            rpt_d   = 1'b1;
            state_d = REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
        REPEAT: begin
          if (rcnt_q == CW'(REPEAT_CYCLES - 1)) begin
            rpt_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    event_d = press_d | rpt_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      event_q   <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign event_o   = event_q;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end: N_BTN independent synchronize/debounce/auto-repeat
// channels. All outputs registered, reset to 0.
//   CLOCK, RESET : clock, synchronous active-high reset
//   btn_raw      : asynchronous raw buttons, active-high
//   btn_level    : debounced levels
//   btn_press    : one-cycle strobe on accepted rising level
//   btn_release  : one-cycle strobe on accepted falling level
//   btn_event    : btn_press or auto-repeat strobe
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_event
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (CLOCK),
      .rst_i    (RESET),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .event_o  (btn_event[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int N = 5;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_event;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLOCK = ~CLOCK;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_event(btn_event)
  );

  // Advance n rising edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] any_out();
    return btn_level | btn_press | btn_release | btn_event;
  endfunction

  initial begin
    logic el, er, ep, ee;

    // ---- reset with all buttons held ----
    RESET   = 1'b1;
    btn_raw = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("reset_outs", any_out(), 5'b0);
    end
    RESET = 1'b0;
    step(5);
    chk("rst_lvl_early", btn_level, 5'b0);
    step(1);
    chk("rst_lvl", btn_level, 5'b11111);
    chk("rst_press", btn_press, 5'b11111);
    chk("rst_event", btn_event, 5'b11111);
    step(1);
    chk("rst_press_1cyc", btn_press, 5'b0);
    chk("rst_lvl_hold", btn_level, 5'b11111);
    btn_raw = 5'b0;
    step(5);
    chk("rel_early", btn_release, 5'b0);
    step(1);
    chk("rel_all", btn_release, 5'b11111);
    chk("rel_lvl", btn_level, 5'b0);
    chk("rel_no_evt", btn_event, 5'b0);
    step(1);
    chk("rel_1cyc", btn_release, 5'b0);
    step(4);

    // ---- clean press/release on channel 0 ----
    btn_raw = 5'b00001;
    step(5);
    chk("clean_lvl_early", btn_level, 5'b0);
    step(1);
    chk("clean_lvl", btn_level, 5'b00001);
    chk("clean_press", btn_press, 5'b00001);
    chk("clean_event", btn_event, 5'b00001);
    step(1);
    chk("clean_press_1cyc", btn_press, 5'b0);
    btn_raw = 5'b0;
    step(5);
    chk("clean_rel_early", btn_release, 5'b0);
    step(1);
    chk("clean_rel", btn_release, 5'b00001);
    chk("clean_rel_lvl", btn_level, 5'b0);
    step(6);

    // ---- bounce on channel 1: 3 high / 1 low never accepted ----
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        step(1);
        chk("bounce", any_out() & 5'b00010, 5'b0);
      end
      btn_raw[1] = 1'b0;
      step(1);
      chk("bounce", any_out() & 5'b00010, 5'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("bounce_tail", any_out(), 5'b0);
    end

    // ---- auto-repeat on channel 2, release collides with repeat ----
    // press at k=6, repeats at 16,19,...,43; repeat due at 46 is
    // replaced by the release strobe.
    btn_raw[2] = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      step(1);
      ep = (k == 6);
      ee = ep || (k >= 16 && k < 46 && ((k - 16) % 3) == 0);
      er = (k == 46);
      el = (k >= 6 && k < 46);
      chk($sformatf("rpt_k%0d", k),
          {1'b0, btn_level[2], btn_release[2], btn_press[2], btn_event[2]},
          {1'b0, el, er, ep, ee});
      if (k == 40) btn_raw[2] = 1'b0;
    end
    step(4);

    // ---- reset mid-HOLD with channels 3 and 4 held ----
    btn_raw = 5'b01000;
    step(2);                                  // k=2
    btn_raw[4] = 1'b1;
    step(4);                                  // k=6
    chk("mh_press3", btn_press, 5'b01000);
    step(2);                                  // k=8
    chk("mh_press4", btn_press, 5'b10000);
    step(3);                                  // k=11
    RESET = 1'b1;
    step(1);                                  // k=12
    chk("mh_reset", any_out(), 5'b0);
    step(1);                                  // k=13
    chk("mh_reset", any_out(), 5'b0);
    RESET = 1'b0;
    for (int k = 14; k <= 18; k++) begin
      step(1);
      chk("mh_after_rst", any_out(), 5'b0);
    end
    step(1);                                  // k=19
    chk("mh_repress", btn_press, 5'b11000);
    chk("mh_relvl", btn_level, 5'b11000);
    chk("mh_reevt", btn_event, 5'b11000);
    step(1);                                  // k=20
    chk("mh_repress_1cyc", btn_press, 5'b0);
    step(8);                                  // k=28
    chk("mh_no_early_rpt", btn_event, 5'b0);
    step(1);                                  // k=29
    chk("mh_first_rpt", btn_event, 5'b11000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
